// File: rtl/uart_mmio.sv
// Memory-mapped full-duplex UART: TX/RX FIFOs, programmable divisor,
// sticky error flags and a level interrupt.
module uart_mmio #(
   parameter int CLK_FREQ_HZ = 25000000,
   parameter int BAUD_RATE   = 115200,
   parameter int TX_DEPTH    = 8,
   parameter int RX_DEPTH    = 8
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        sel,
   input  logic [1:0]  reg_addr,
   input  logic [31:0] wdata,
   input  logic        wstrb,
   input  logic        rstrb,
   output logic [31:0] rdata,
   input  logic        uart_rx,
   output logic        uart_tx,
   output logic        irq
);
   localparam int TXW = $clog2(TX_DEPTH);
   localparam int RXW = $clog2(RX_DEPTH);
   localparam logic [15:0] DIV_RST = 16'(CLK_FREQ_HZ / BAUD_RATE);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic [15:0] div;
   logic [1:0]  irq_en;
   logic        rx_ovr, frame_err, tx_ovf;

   logic wr_data, rd_data, wr_stat, wr_div, wr_irq;
   assign wr_data = sel & wstrb & (reg_addr == 2'd0);
   assign rd_data = sel & rstrb & (reg_addr == 2'd0);
   assign wr_stat = sel & wstrb & (reg_addr == 2'd1);
   assign wr_div  = sel & wstrb & (reg_addr == 2'd2);
   assign wr_irq  = sel & wstrb & (reg_addr == 2'd3);

   logic unused;
   assign unused = ^wdata[31:16];

   // TX FIFO
   logic [7:0]   tx_mem [TX_DEPTH];
   logic [TXW:0] tx_wp, tx_rp;
   logic         tx_fempty, tx_full, tx_push, tx_pop;
   logic [7:0]   tx_head;

   assign tx_fempty = tx_wp == tx_rp;
   assign tx_full   = (tx_wp[TXW] != tx_rp[TXW]) &&
                      (tx_wp[TXW-1:0] == tx_rp[TXW-1:0]);
   assign tx_push   = wr_data & (~tx_full | tx_pop);
   assign tx_head   = tx_mem[tx_rp[TXW-1:0]];

   always_ff @(posedge clk)
      if (tx_push) tx_mem[tx_wp[TXW-1:0]] <= wdata[7:0];

   // RX FIFO
   logic [7:0]   rx_mem [RX_DEPTH];
   logic [RXW:0] rx_wp, rx_rp;
   logic         rx_fempty, rx_full, rx_push, rx_pop, rx_req, rx_ferr;
   logic [7:0]   rx_head, rx_sh;

   assign rx_fempty = rx_wp == rx_rp;
   assign rx_full   = (rx_wp[RXW] != rx_rp[RXW]) &&
                      (rx_wp[RXW-1:0] == rx_rp[RXW-1:0]);
   assign rx_pop    = rd_data & ~rx_fempty;
   assign rx_push   = rx_req & (~rx_full | rx_pop);
   assign rx_head   = rx_mem[rx_rp[RXW-1:0]];

   always_ff @(posedge clk)
      if (rx_push) rx_mem[rx_wp[RXW-1:0]] <= rx_sh;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tx_wp <= '0;
         tx_rp <= '0;
         rx_wp <= '0;
         rx_rp <= '0;
      end else begin
         if (tx_push) tx_wp <= tx_wp + 1'b1;
         if (tx_pop)  tx_rp <= tx_rp + 1'b1;
         if (rx_push) rx_wp <= rx_wp + 1'b1;
         if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      end
   end

   // TX engine; the divisor is frozen per frame
   state_t      tx_st;
   logic [15:0] tx_div, tx_cnt;
   logic [7:0]  tx_sh;
   logic [2:0]  tx_bit;
   logic        tx_tick, tx_empty;

   assign tx_tick  = tx_cnt == tx_div - 16'd1;
   assign tx_pop   = ~tx_fempty &
                     ((tx_st == IDLE) | ((tx_st == STOP) & tx_tick));
   assign tx_empty = tx_fempty & (tx_st == IDLE);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tx_st   <= IDLE;
         tx_div  <= DIV_RST;
         tx_cnt  <= '0;
         tx_sh   <= '0;
         tx_bit  <= '0;
         uart_tx <= 1'b1;
      end else begin
         unique case (tx_st)
            IDLE: if (tx_pop) begin
               tx_st   <= START;
               tx_sh   <= tx_head;
               tx_div  <= div;
               tx_cnt  <= '0;
               uart_tx <= 1'b0;
            end
            START: if (tx_tick) begin
               tx_st   <= DATA;
               tx_cnt  <= '0;
               tx_bit  <= '0;
               uart_tx <= tx_sh[0];
            end else tx_cnt <= tx_cnt + 16'd1;
            DATA: if (tx_tick) begin
               tx_cnt <= '0;
               if (tx_bit == 3'd7) begin
                  tx_st   <= STOP;
                  uart_tx <= 1'b1;
               end else begin
                  tx_bit  <= tx_bit + 3'd1;
                  tx_sh   <= {1'b0, tx_sh[7:1]};
                  uart_tx <= tx_sh[1];
               end
            end else tx_cnt <= tx_cnt + 16'd1;
            STOP: if (tx_tick) begin
               tx_cnt <= '0;
               if (tx_pop) begin
                  tx_st   <= START;
                  tx_sh   <= tx_head;
                  tx_div  <= div;
                  uart_tx <= 1'b0;
               end else tx_st <= IDLE;
            end else tx_cnt <= tx_cnt + 16'd1;
         endcase
      end
   end

   // RX engine behind a 2-flop synchroniser
   state_t      rx_st;
   logic        rx_s1, rx_s2, rx_prev, rx_tick;
   logic [15:0] rx_div, rx_cnt, rx_lim;
   logic [2:0]  rx_bit;

   assign rx_lim  = (rx_st == START) ? {1'b0, rx_div[15:1]} - 16'd1
                                     : rx_div - 16'd1;
   assign rx_tick = rx_cnt == rx_lim;
   assign rx_req  = (rx_st == STOP) & rx_tick & rx_s2;
   assign rx_ferr = (rx_st == STOP) & rx_tick & ~rx_s2;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rx_s1   <= 1'b1;
         rx_s2   <= 1'b1;
         rx_prev <= 1'b1;
         rx_st   <= IDLE;
         rx_div  <= DIV_RST;
         rx_cnt  <= '0;
         rx_sh   <= '0;
         rx_bit  <= '0;
      end else begin
         rx_s1   <= uart_rx;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
         unique case (rx_st)
            IDLE: if (rx_prev & ~rx_s2) begin
               rx_st  <= START;
               rx_div <= div;
               rx_cnt <= '0;
            end
            START: if (rx_tick) begin
               rx_cnt <= '0;
               rx_bit <= '0;
               rx_st  <= rx_s2 ? IDLE : DATA;
            end else rx_cnt <= rx_cnt + 16'd1;
            DATA: if (rx_tick) begin
               rx_cnt <= '0;
               rx_sh  <= {rx_s2, rx_sh[7:1]};
               if (rx_bit == 3'd7) rx_st <= STOP;
               else rx_bit <= rx_bit + 3'd1;
            end else rx_cnt <= rx_cnt + 16'd1;
            STOP: if (rx_tick) rx_st <= IDLE;
               else rx_cnt <= rx_cnt + 16'd1;
         endcase
      end
   end

   // control registers; a set beats a same-cycle clear
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         div       <= DIV_RST;
         irq_en    <= '0;
         rx_ovr    <= 1'b0;
         frame_err <= 1'b0;
         tx_ovf    <= 1'b0;
         irq       <= 1'b0;
      end else begin
         if (wr_div) div <= (wdata[15:0] < 16'd4) ? 16'd4 : wdata[15:0];
         if (wr_irq) irq_en <= wdata[1:0];
         rx_ovr    <= (rx_req & ~rx_push) |
                      (rx_ovr & ~(wr_stat & wdata[4]));
         frame_err <= rx_ferr | (frame_err & ~(wr_stat & wdata[5]));
         tx_ovf    <= (wr_data & ~tx_push) |
                      (tx_ovf & ~(wr_stat & wdata[6]));
         irq       <= (irq_en[0] & ~rx_fempty) | (irq_en[1] & tx_empty);
      end
   end

   always_comb begin
      rdata = '0;
      if (sel) begin
         unique case (reg_addr)
            2'd0: rdata = {22'b0, ~rx_fempty, 1'b0, rx_head};
            2'd1: rdata = {22'b0, tx_full, 2'b0, tx_ovf, frame_err, rx_ovr,
                           rx_full, ~rx_fempty, tx_empty, tx_full};
            2'd2: rdata = {16'b0, div};
            2'd3: rdata = {30'b0, irq_en};
         endcase
      end
   end
endmodule

// File: tb/tb_uart_mmio.sv
// Scoreboard bench for uart_mmio: stimulus queues expectations,
// negedge monitors pop and compare.
module tb_uart_mmio;
   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        sel = 1'b0, wstrb = 1'b0, rstrb = 1'b0;
   logic [1:0]  reg_addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        uart_rx, uart_tx, irq;
   logic        peek = 1'b0, loop = 1'b0, rx_drv = 1'b1;

   assign uart_rx = loop ? uart_tx : rx_drv;
   always #5 clk = ~clk;

   uart_mmio dut (
      .clk(clk), .resetn(resetn), .sel(sel), .reg_addr(reg_addr),
      .wdata(wdata), .wstrb(wstrb), .rstrb(rstrb), .rdata(rdata),
      .uart_rx(uart_rx), .uart_tx(uart_tx), .irq(irq)
   );

   typedef struct {
      string       nm;
      int          kd;
      logic [31:0] ev;
   } exp_t;

   exp_t rq[$];
   logic tq[$];
   int   n_chk = 0;
   int   n_pass = 0;
   exp_t e;
   logic b;

   task automatic check(string nm, logic [31:0] act, logic [31:0] ev);
      n_chk++;
      if (act === ev) n_pass++;
      else $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, ev);
   endtask

   // kd 0 = rdata, 1 = irq, 2 = uart_tx
   always @(negedge clk) begin
      if ((sel && rstrb) || peek) begin
         if (rq.size() == 0) begin
            n_chk++;
            $display("FAIL scoreboard: output with no expectation");
         end else begin
            e = rq.pop_front();
            case (e.kd)
               0: check(e.nm, rdata, e.ev);
               1: check(e.nm, {31'b0, irq}, e.ev);
               default: check(e.nm, {31'b0, uart_tx}, e.ev);
            endcase
         end
      end
      if (tq.size() > 0) begin
         b = tq.pop_front();
         check("tx_bit", {31'b0, uart_tx}, {31'b0, b});
      end
   end

   task automatic tick(int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(logic [1:0] a, logic [31:0] d);
      sel = 1; wstrb = 1; reg_addr = a; wdata = d;
      tick();
      sel = 0; wstrb = 0;
   endtask

   task automatic rd(logic [1:0] a, logic [31:0] x, string nm);
      rq.push_back('{nm: nm, kd: 0, ev: x});
      sel = 1; rstrb = 1; reg_addr = a;
      tick();
      sel = 0; rstrb = 0;
   endtask

   task automatic pk(int k, logic [31:0] x, string nm);
      rq.push_back('{nm: nm, kd: k, ev: x});
      peek = 1;
      tick();
      peek = 0;
   endtask

   task automatic push_ones(int n);
      repeat (n) tq.push_back(1'b1);
   endtask

   task automatic push_frame(logic [7:0] d);
      repeat (4) tq.push_back(1'b0);
      for (int i = 0; i < 8; i++) repeat (4) tq.push_back(d[i]);
      repeat (4) tq.push_back(1'b1);
   endtask

   task automatic drain();
      int t = 0;
      while (tq.size() > 0 && t < 2000) begin
         tick();
         t++;
      end
      if (tq.size() > 0) begin
         n_chk++;
         $display("FAIL drain: %0d bits left, want 0", tq.size());
         tq.delete();
      end
   endtask

   task automatic send_rx(logic [7:0] d, logic stp, int dv);
      rx_drv = 0;
      tick(dv);
      for (int i = 0; i < 8; i++) begin
         rx_drv = d[i];
         tick(dv);
      end
      rx_drv = stp;
      tick(dv);
      rx_drv = 1;
      tick(dv);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation timeout");
      $fatal(1);
   end

   initial begin
      tick(3);
      pk(2, 1, "rst_tx");
      pk(1, 0, "rst_irq");
      resetn = 1;
      tick();
      rd(1, 32'h002, "rst_status");
      rd(2, 32'd217, "rst_div");
      rd(3, 32'h0, "rst_irqen");

      wstrb = 1; reg_addr = 0; wdata = 32'h77;
      tick();
      wstrb = 0;
      rstrb = 1; reg_addr = 2;
      pk(0, 32'h0, "nosel_rdata");
      rstrb = 0;
      rd(1, 32'h002, "nosel_status");

      wr(2, 32'd2);
      rd(2, 32'd4, "div_clamp");
      wr(2, 32'd4);

      push_ones(2);
      push_frame(8'h55);
      push_ones(4);
      wr(0, 32'h55);
      drain();
      rd(1, 32'h002, "tx_done_status");

      push_ones(2);
      for (int i = 0; i < 9; i++) push_frame(8'(i));
      push_ones(8);
      for (int i = 0; i < 10; i++) begin
         sel = 1; wstrb = 1; reg_addr = 0; wdata = i;
         tick();
      end
      sel = 0; wstrb = 0;
      rd(1, 32'h241, "ovf_status");
      wr(1, 32'h40);
      rd(1, 32'h201, "ovf_clear");
      drain();
      rd(1, 32'h002, "ovf_idle");

      wr(2, 32'd8);
      wr(3, 32'd1);
      loop = 1;
      wr(0, 32'hA3);
      tick(100);
      pk(1, 1, "lb_irq_hi");
      rd(0, 32'h2A3, "lb_data");
      rd(1, 32'h002, "lb_status");
      pk(1, 0, "lb_irq_lo");
      loop = 0;
      wr(3, 32'd0);

      wr(2, 32'd16);
      send_rx(8'h5A, 1'b0, 16);
      tick(20);
      rd(1, 32'h022, "ferr_status");
      wr(1, 32'h20);

      rx_drv = 0;
      tick(2);
      rx_drv = 1;
      tick(40);
      rd(1, 32'h002, "glitch_status");

      for (int i = 0; i < 9; i++) send_rx(8'(8'h30 + i), 1'b1, 16);
      tick(20);
      rd(1, 32'h01E, "rxovr_status");
      for (int i = 0; i < 8; i++) rd(0, 32'h230 + i, "rx_order");
      rd(1, 32'h012, "rx_drained");

      wr(2, 32'd4);
      wr(0, 32'h00);
      wr(0, 32'h00);
      tick(6);
      pk(2, 0, "pre_rst_tx");
      resetn = 0;
      pk(2, 1, "rst_mid_tx");
      resetn = 1;
      rd(1, 32'h002, "rst_mid_status");
      rd(2, 32'd217, "rst_mid_div");
      push_ones(40);
      drain();

      tick(2);
      if (rq.size() != 0) begin
         n_chk++;
         $display("FAIL leftover: %0d expectations, want 0", rq.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/uart_mmio.md
Name: uart_mmio

Overview:
Memory-mapped full-duplex UART peripheral for the SOC IO page. It replaces the fixed-rate, transmit-only emitter and the ad-hoc status decode. It adds parametrised TX/RX FIFOs, a receiver, a runtime-programmable baud divisor, sticky error flags and an interrupt output. It connects directly to the processor bus signals once the IO page and UART word range have been decoded.

Parameters:
CLK_FREQ_HZ, 25000000, system clock frequency; used only for the divisor reset value
BAUD_RATE, 115200, default baud; DIV reset value = CLK_FREQ_HZ/BAUD_RATE (integer division, 217 at the defaults)
TX_DEPTH, 8, TX FIFO entries; power of two, >= 2
RX_DEPTH, 8, RX FIFO entries; power of two, >= 2

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
sel  in  1  UART register window selected (IO page and UART word range)
reg_addr  in  2  register word index
wdata  in  32  write data
wstrb  in  1  write strobe (OR of mem_wmask); qualified by sel
rstrb  in  1  read strobe; qualified by sel
rdata  out  32  read data; combinational from current state, zero-latency
uart_rx  in  1  serial input, asynchronous
uart_tx  out  1  serial output, idle high
irq  out  1  level interrupt

Behaviour:
- Reset (async, resetn=0):
  - FIFOs emptied; all sticky flags cleared.
  - DIV = CLK_FREQ_HZ/BAUD_RATE; IRQ_EN = 0.
  - uart_tx = 1 immediately; irq = 0; TX and RX state machines go to IDLE. This applies mid-frame as well.
  - rx synchroniser flops reset to 1.
- Register map (reg_addr):
  - 0 DATA
    - Write: push wdata[7:0] into the TX FIFO. If the FIFO is full, the byte is dropped and TX_OVF is set.
    - Read: rdata = {22'b0, rx_nonempty, 1'b0, rx_head[7:0]}, where rx_head is the byte at the head of the RX FIFO and bit 9 is rx_nonempty.
    - Read with rstrb pops the RX FIFO on that clock edge. Popping an empty FIFO has no effect.
  - 1 STATUS (read)
    - bit0 tx_full, bit1 tx_empty, bit2 rx_nonempty, bit3 rx_full.
    - bit4 RX_OVR (sticky), bit5 FRAME_ERR (sticky), bit6 TX_OVF (sticky).
    - bit9 = tx_full, for compatibility with existing firmware that polls bit 9 as "busy".
    - All other bits read 0.
    - Write: writing 1 to bit4/5/6 clears the corresponding flag. A clear and a set in the same cycle resolve to set.
  - 2 DIV (RW): 16-bit clocks-per-bit in bits [15:0]. A written value < 4 is stored as 4. Reads return {16'b0, DIV}.
  - 3 IRQ_EN (RW, bits [1:0]): irq = (IRQ_EN[0] & rx_nonempty) | (IRQ_EN[1] & tx_empty). irq is registered, so it has one cycle of latency.
- FIFOs: circular buffers with log2(DEPTH)+1-bit pointers (wrap bit distinguishes full from empty).
  - A push to a full FIFO is accepted if a pop occurs in the same cycle.
  - Simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
- TX FSM (states IDLE, START, DATA, STOP):
  - IDLE → START when the TX FIFO is non-empty. On that transition, pop the head into the shift register and latch DIV into a frame divisor.
  - Each state drives its bit for exactly frame-divisor clocks: START drives 0; DATA drives 8 bits, LSB first; STOP drives 1.
  - STOP → START directly if the FIFO is non-empty (back-to-back frames, no idle gap); otherwise STOP → IDLE.
  - A DIV write mid-frame takes effect on the next frame only.
  - Timing: the first start-bit cycle occurs 1 clock after the FIFO becomes non-empty. A frame lasts 10×DIV clocks.
- RX path: uart_rx passes through a 2-flop synchroniser. The RX FSM has states IDLE, START, DATA, STOP.
  - IDLE → START on a synchronised falling edge; the frame divisor is latched at this point.
  - START: after DIV/2 clocks, re-sample. If the line is 1, treat it as a false start and return to IDLE with no flag. Otherwise go to DATA.
  - DATA: sample every DIV clocks (mid-bit), 8 bits, shifting LSB first.
  - STOP: sample after DIV clocks.
    - Sample = 1: push the byte into the RX FIFO. If the push is refused (full), drop the byte and set RX_OVR.
    - Sample = 0: discard the byte and set FRAME_ERR. The FSM then waits in IDLE until the line is high before re-arming.
- Accesses with sel=0 have no effect. rdata = 0 when sel=0.

Test Plan:
- Reset values: after reset, STATUS reads 0x002 (tx_empty=1, all others 0); DIV reads 217; uart_tx=1; irq=0.
- TX single byte: write DIV=4, write DATA=0x55. Required: uart_tx shows 0, then 1,0,1,0,1,0,1,0, then 1, each bit held exactly 4 clocks, with start beginning 1 clock after the write. tx_empty returns to 1 at the end of the STOP bit.
- TX overflow and back-to-back: with DIV=4, write 10 bytes (0x00–0x09) in consecutive cycles. Required: the first byte starts transmission, so 8 remain queued and one write is dropped, setting TX_OVF (STATUS bit6=1). Frames are contiguous (40 clocks each, no gap). Writing 0x40 to STATUS clears TX_OVF.
- RX loopback: uart_tx tied to uart_rx, DIV=8, IRQ_EN=1, send 0xA3. Required: irq rises after the frame, DATA read returns 0x2A3, the next STATUS read has bit2=0, and irq falls.
- RX errors:
  - Drive a frame with stop bit 0 → FRAME_ERR=1 and the RX FIFO stays empty.
  - Drive a 2-clock low glitch at DIV=16 → no byte and no flag.
  - Receive RX_DEPTH+1 bytes without reading → rx_full=1 and RX_OVR=1. The first RX_DEPTH bytes read back in order.
- Reset mid-frame: assert resetn=0 during the DATA state of TX. Required: uart_tx=1 in the same cycle, the FIFOs are empty, and no partial frame resumes after release.
